aes_dec_block_sequencer: RTL and testbench
==========================================

// Module: aes_dec_block_sequencer
// PURPOSE
//  Streams 128-bit ciphertext blocks, read from the SD-card buffer, through one shared ASMD_Decryption core.
//  Holds the key, launches a core run per block and waits for core done.
//  Returns plaintext on a valid/ready stream, counts blocks and recovers a hung core with a watchdog.
//  Sits between the SD read FIFO and the plaintext sink; it is the only driver of the core's decrypt/key/text inputs.
// PARAMETERS
//  BLK_CNT_W   16    width of processed-block counter
//  TIMEOUT     255   max cycles in WAIT before abort (must be > worst-case core latency incl. key expansion)
//  TO_W        8     width of watchdog counter, >= clog2(TIMEOUT+1)
// PORTS
//  clock        in   1          system clock
//  reset        in   1          synchronous, active-high
//  key_in       in   128        cipher key
//  key_load     in   1          latch key_in; honoured only in IDLE
//  iv_in        in   128        CBC IV, latched with key_load (ignored unless AES_CBC_EN)
//  s_ct_data    in   128        ciphertext block
//  s_ct_valid   in   1          ciphertext valid
//  s_ct_ready   out  1          sequencer can accept block
//  m_pt_data    out  128        plaintext block
//  m_pt_valid   out  1          plaintext valid
//  m_pt_ready   in   1          sink accepts plaintext
//  core_decrypt out  1          start pulse to core
//  core_ct      out  128        registered ciphertext to core
//  core_key     out  128        registered key to core
//  core_rst     out  1          one-cycle core reset on timeout (OR'd with reset at top)
//  core_dout    in   128        core plaintext
//  core_done    in   1          core completion (level)
//  busy         out  1          high in any state except IDLE
//  err_timeout  out  1          sticky watchdog flag
//  blk_count    out  BLK_CNT_W  blocks delivered (wraps)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0; key_valid/key/IV/ct regs 0; blk_count 0; err_timeout 0.
//  FSM:
//   IDLE  - s_ct_ready = key_valid && !key_load.
//           key_load: latch key, IV; set key_valid. A key_load with s_ct_valid in the same cycle loads the key only.
//           Handshake s_ct_valid&&s_ct_ready: latch s_ct_data into core_ct -> START.
//   START - core_decrypt=1 for exactly 1 cycle; watchdog cleared -> WAIT.
//   WAIT  - watchdog increments each cycle.
//           core_done=1: capture core_dout into m_pt_data -> OUT.
//           If core_done and watchdog==TIMEOUT coincide, done wins.
//           Watchdog==TIMEOUT without done: set err_timeout, pulse core_rst, drop block -> IDLE.
//   OUT   - m_pt_valid=1, data stable until m_pt_ready.
//           On handshake: blk_count+1 (mod 2^BLK_CNT_W) -> IDLE.
//  Latency: s_ct handshake to m_pt_valid = core latency + 3 cycles.
//  One block in flight; no new s_ct accepted outside IDLE; key_load outside IDLE ignored.
//  core_done high while in IDLE/START is ignored (stale level).
//  err_timeout cleared only by reset.
//  Reset mid-operation: immediate return to IDLE, in-flight block lost, key must be reloaded.
// CONFIGURATION
//  AES_CBC_EN defined:
//   - m_pt_data = core_dout ^ chain_reg.
//   - chain_reg loads IV on key_load; loads core_ct on each OUT handshake (never on timeout).
//  AES_CBC_EN undefined: ECB, m_pt_data = core_dout; iv_in unused; no chain_reg.
// STRUCTURE
//  Package aes_seq_pkg: state encoding localparams (IDLE=0,START=1,WAIT=2,OUT=3), AES_BLK_W=128.
//  One sub-module: aes_seq_watchdog (clear, enable, TIMEOUT compare -> expired).
//  FSM, regs, stream logic and optional CBC XOR stay in the top.
// TESTING
//  1 Load key 000102..0f, send FIPS-197 ct 69c4e0d8..c55a with sink ready -> pt 00112233..eeff, blk_count=1, one core_decrypt pulse.
//  2 Sink m_pt_ready=0 for 20 cycles -> m_pt_valid held, data stable, s_ct_ready=0, blk_count unchanged until accept.
//  3 Stub core never asserts done -> err_timeout=1 after TIMEOUT+1 WAIT cycles, core_rst 1-cycle pulse, FSM back to IDLE, no m_pt_valid.
//  4 s_ct_valid before any key_load -> s_ct_ready=0; key_load+s_ct_valid same cycle -> key latched, block taken next cycle.
//  5 AES_CBC_EN, IV=000102..0f, SP800-38A CBC blocks 1-2 -> 6bc1bee2..172a then ae2d8a57..8e51.
//  6 reset asserted in WAIT -> next cycle all outputs 0, state IDLE; 2^BLK_CNT_W blocks -> blk_count wraps to 0.

Source files
------------

// File: rtl/aes_seq_pkg.sv
// Shared types and constants for the AES decrypt block sequencer.
package aes_seq_pkg;

  localparam int AES_BLK_W = 128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_OUT   = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ST_IDLE,
    S_START = ST_START,
    S_WAIT  = ST_WAIT,
    S_OUT   = ST_OUT
  } seq_state_t;

endpackage

// File: rtl/aes_seq_watchdog.sv
// Up-counting watchdog; expired is high while the count equals TIMEOUT.
module aes_seq_watchdog #(
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [TO_W-1:0] count;

  assign expired = (count == TO_W'(TIMEOUT));

  // Holds at TIMEOUT so expired cannot slip past by wrapping.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/aes_dec_block_sequencer.sv
// Feeds ciphertext blocks one at a time through a shared AES decrypt core.
// Define AES_CBC_EN to chain blocks in CBC mode; otherwise plaintext is ECB.
//
//  state | meaning
//  IDLE  | waiting for key_load or a ciphertext block
//  START | one-cycle decrypt pulse to the core, watchdog cleared
//  WAIT  | waiting for core_done under watchdog
//  OUT   | plaintext held on m_pt until accepted
module aes_dec_block_sequencer
  import aes_seq_pkg::*;
#(
  parameter int BLK_CNT_W = 16,
  parameter int TIMEOUT   = 255,
  parameter int TO_W      = 8
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [AES_BLK_W-1:0] key_in,
  input  logic                 key_load,
  input  logic [AES_BLK_W-1:0] iv_in,
  input  logic [AES_BLK_W-1:0] s_ct_data,
  input  logic                 s_ct_valid,
  output logic                 s_ct_ready,
  output logic [AES_BLK_W-1:0] m_pt_data,
  output logic                 m_pt_valid,
  input  logic                 m_pt_ready,
  output logic                 core_decrypt,
  output logic [AES_BLK_W-1:0] core_ct,
  output logic [AES_BLK_W-1:0] core_key,
  output logic                 core_rst,
  input  logic [AES_BLK_W-1:0] core_dout,
  input  logic                 core_done,
  output logic                 busy,
  output logic                 err_timeout,
  output logic [BLK_CNT_W-1:0] blk_count
);

  seq_state_t state, state_nxt;
  logic key_valid;
  logic wd_clear, wd_en, wd_expired;
  logic accept, deliver, timeout;
  logic [AES_BLK_W-1:0] pt_mask;

  aes_seq_watchdog #(.TIMEOUT(TIMEOUT), .TO_W(TO_W)) u_watchdog (
    .clock  (clock),
    .reset  (reset),
    .clear  (wd_clear),
    .enable (wd_en),
    .expired(wd_expired)
  );

  always_comb begin
    state_nxt    = state;
    s_ct_ready   = 1'b0;
    core_decrypt = 1'b0;
    m_pt_valid   = 1'b0;
    wd_clear     = 1'b0;
    wd_en        = 1'b0;
    accept       = 1'b0;
    deliver      = 1'b0;
    timeout      = 1'b0;
    case (state)
      S_IDLE: begin
        // A key_load cycle never takes a block, so the new key applies to it.
        s_ct_ready = key_valid && !key_load;
        accept     = s_ct_valid && key_valid && !key_load;
        if (accept) state_nxt = S_START;
      end
      S_START: begin
        core_decrypt = 1'b1;
        wd_clear     = 1'b1;
        state_nxt    = S_WAIT;
      end
      S_WAIT: begin
        wd_en = 1'b1;
        if (core_done) begin
          state_nxt = S_OUT;
        end else if (wd_expired) begin
          timeout   = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      S_OUT: begin
        m_pt_valid = 1'b1;
        deliver    = m_pt_ready;
        if (m_pt_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      key_valid   <= 1'b0;
      core_key    <= '0;
      core_ct     <= '0;
      m_pt_data   <= '0;
      core_rst    <= 1'b0;
      err_timeout <= 1'b0;
      blk_count   <= '0;
    end else begin
      state    <= state_nxt;
      core_rst <= 1'b0;
      if (state == S_IDLE && key_load) begin
        core_key  <= key_in;
        key_valid <= 1'b1;
      end
      if (accept) core_ct <= s_ct_data;
      if (state == S_WAIT && core_done) m_pt_data <= core_dout ^ pt_mask;
      if (timeout) begin
        err_timeout <= 1'b1;
        core_rst    <= 1'b1;
      end
      if (deliver) blk_count <= blk_count + 1'b1;
    end
  end

`ifdef AES_CBC_EN
  logic [AES_BLK_W-1:0] chain_reg;

  // Chain advances only on delivered blocks; a timed-out block leaves it untouched.
  always_ff @(posedge clock) begin
    if (reset) begin
      chain_reg <= '0;
    end else if (state == S_IDLE && key_load) begin
      chain_reg <= iv_in;
    end else if (deliver) begin
      chain_reg <= core_ct;
    end
  end

  assign pt_mask = chain_reg;
`else
  logic unused_iv;
  assign unused_iv = ^iv_in;
  assign pt_mask   = '0;
`endif

endmodule

// File: tb/tb_aes_dec_block_sequencer.sv
// Bench: stub core + transaction-level model checked every cycle, plus directed literal checks.
module tb_aes_dec_block_sequencer;

  localparam int BLK_CNT_W = 4;
  localparam int TIMEOUT   = 20;
  localparam int TO_W      = 5;
`ifdef AES_CBC_EN
  localparam bit CBC = 1'b1;
`else
  localparam bit CBC = 1'b0;
`endif

  localparam logic [127:0] K_FIPS  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT_FIPS = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] PT_FIPS = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K_SP    = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] IV_SP   = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] CT1     = 128'h7649abac8119b246cee98e9b12e9197d;
  localparam logic [127:0] PT1     = 128'h6bc1bee22e409f96e93d7e117393172a;
  localparam logic [127:0] CT2     = 128'h5086cb9b507219ee95db113a917678b2;
  localparam logic [127:0] PT2     = 128'hae2d8a571e03ac9c9eb76fac45af8e51;

  logic clock, reset, key_load, s_ct_valid, s_ct_ready, m_pt_valid, m_pt_ready;
  logic core_decrypt, core_rst, core_done, busy, err_timeout;
  logic [127:0] key_in, iv_in, s_ct_data, m_pt_data, core_ct, core_key, core_dout;
  logic [BLK_CNT_W-1:0] blk_count;

  aes_dec_block_sequencer #(.BLK_CNT_W(BLK_CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .clock(clock), .reset(reset), .key_in(key_in), .key_load(key_load), .iv_in(iv_in),
    .s_ct_data(s_ct_data), .s_ct_valid(s_ct_valid), .s_ct_ready(s_ct_ready),
    .m_pt_data(m_pt_data), .m_pt_valid(m_pt_valid), .m_pt_ready(m_pt_ready),
    .core_decrypt(core_decrypt), .core_ct(core_ct), .core_key(core_key), .core_rst(core_rst),
    .core_dout(core_dout), .core_done(core_done), .busy(busy),
    .err_timeout(err_timeout), .blk_count(blk_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Stand-in decrypt core: known vectors by table, anything else by a fixed bijection.
  function automatic logic [127:0] core_fn(input logic [127:0] ct, input logic [127:0] key);
    if (key == K_FIPS && ct == CT_FIPS) return PT_FIPS;
    if (key == K_SP && ct == CT1) return PT1 ^ IV_SP;
    if (key == K_SP && ct == CT2) return PT2 ^ CT1;
    return {ct[63:0], ct[127:64]} ^ key;
  endfunction

  // Model state (module scope so the stub core can take per-block latency from it)
  bit inflight = 0, kv = 0, err_m = 0, rst_m = 0, m_hang = 0;
  int n = 0, m_lat = 1, blk_m = 0;
  logic [127:0] key_m = '0, chain_m = '0, ct_m = '0, exp_pt = '0, last_out = '0;
  int dec_cnt = 0, rst_cnt = 0, valid_cnt = 0;
  int cur_lat = 1;
  bit cur_hang = 0;

  logic [127:0] stub_ct, stub_key, stub_dout;
  logic stub_done;
  int stub_cnt;
  assign core_done = stub_done;
  assign core_dout = stub_dout;

  always @(posedge clock) begin
    if (reset || core_rst) begin
      stub_done <= 1'b0;
      stub_cnt  <= 0;
      stub_dout <= '0;
    end else if (core_decrypt) begin
      stub_done <= 1'b0;
      stub_cnt  <= m_hang ? 0 : m_lat;
      stub_ct   <= core_ct;
      stub_key  <= core_key;
    end else if (stub_cnt != 0) begin
      stub_cnt <= stub_cnt - 1;
      if (stub_cnt == 1) begin
        stub_done <= 1'b1;
        stub_dout <= core_fn(stub_ct, stub_key);
      end
    end
  end

  // Model: n counts cycles since the accepting cycle; plaintext due at n >= latency+3,
  // timeout fires on the cycle n == TIMEOUT+2 (TIMEOUT+1 wait cycles after the start cycle).
  initial forever begin
    bit exp_valid;
    @(negedge clock);
    exp_valid = inflight && !m_hang && (n >= m_lat + 3);
    chk("busy", busy, inflight);
    chk("s_ct_ready", s_ct_ready, !inflight && kv && !key_load);
    chk("core_decrypt", core_decrypt, inflight && n == 1);
    chk("m_pt_valid", m_pt_valid, exp_valid);
    if (exp_valid) chk("m_pt_data", m_pt_data, exp_pt);
    chk("err_timeout", err_timeout, err_m);
    chk("core_rst", core_rst, rst_m);
    chk("blk_count", blk_count, blk_m);
    if (inflight) begin
      chk("core_key", core_key, key_m);
      chk("core_ct", core_ct, ct_m);
    end
    if (core_decrypt) dec_cnt++;
    if (core_rst) rst_cnt++;
    if (m_pt_valid) valid_cnt++;
    if (m_pt_valid && m_pt_ready) last_out = m_pt_data;
    rst_m = 0;
    if (reset) begin
      inflight = 0; n = 0; kv = 0; key_m = '0; chain_m = '0; blk_m = 0; err_m = 0;
    end else if (!inflight) begin
      if (key_load) begin
        kv = 1; key_m = key_in; chain_m = iv_in;
      end else if (kv && s_ct_valid) begin
        inflight = 1; n = 1; ct_m = s_ct_data; m_lat = cur_lat; m_hang = cur_hang;
        exp_pt = core_fn(ct_m, key_m) ^ (CBC ? chain_m : 128'h0);
      end
    end else if (exp_valid && m_pt_ready) begin
      inflight = 0; blk_m = (blk_m + 1) % (1 << BLK_CNT_W); chain_m = ct_m;
    end else if (m_hang && n == TIMEOUT + 2) begin
      inflight = 0; err_m = 1; rst_m = 1;
    end else begin
      n++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_key(input logic [127:0] k, input logic [127:0] iv);
    key_in = k; iv_in = iv; key_load = 1'b1;
    tick();
    key_load = 1'b0;
  endtask

  task automatic send(input logic [127:0] ct, input int lat, input bit hang);
    bit ok = 0;
    cur_lat = lat; cur_hang = hang; s_ct_data = ct; s_ct_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      ok = s_ct_ready;
      tick();
    end
    s_ct_valid = 1'b0;
    chk("send_handshake", ok, 1);
  endtask

  task automatic wait_idle(input bit rand_ready);
    bit ok = 0;
    for (int i = 0; i < TIMEOUT + 60 && !ok; i++) begin
      @(negedge clock);
      ok = !busy;
      tick();
      if (rand_ready) m_pt_ready = $urandom_range(0, 1);
    end
    m_pt_ready = 1'b1;
    chk("wait_idle", ok, 1);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int d0, r0, v0, cycles;
    bit seen;
    logic [127:0] held;
    reset = 1'b1; key_in = '0; key_load = 1'b0; iv_in = '0;
    s_ct_data = '0; s_ct_valid = 1'b0; m_pt_ready = 1'b0;
    tick();
    tick();
    @(negedge clock);
    chk("rst_busy", busy, 0);
    chk("rst_s_ct_ready", s_ct_ready, 0);
    chk("rst_m_pt_data", m_pt_data, 0);
    chk("rst_blk_count", blk_count, 0);
    reset = 1'b0;
    tick();

    // 1: FIPS-197 vector, sink ready
    load_key(K_FIPS, '0);
    m_pt_ready = 1'b1;
    d0 = dec_cnt;
    send(CT_FIPS, 5, 0);
    wait_idle(0);
    chk("t1_pt", last_out, PT_FIPS);
    chk("t1_blk_count", blk_count, 1);
    chk("t1_decrypt_pulses", dec_cnt - d0, 1);

    // 2: sink back-pressure for 20 cycles
    m_pt_ready = 1'b0;
    send({$urandom, $urandom, $urandom, $urandom}, 3, 0);
    seen = 0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clock);
      seen = m_pt_valid;
      tick();
    end
    chk("t2_valid_seen", seen, 1);
    held = m_pt_data;
    s_ct_valid = 1'b1;
    repeat (20) tick();
    @(negedge clock);
    chk("t2_valid_held", m_pt_valid, 1);
    chk("t2_data_stable", m_pt_data, held);
    chk("t2_s_ct_ready", s_ct_ready, 0);
    chk("t2_blk_count_hold", blk_count, 1);
    s_ct_valid = 1'b0;
    tick();
    m_pt_ready = 1'b1;
    wait_idle(0);
    chk("t2_blk_count", blk_count, 2);

    // 3: hung core
    r0 = rst_cnt; v0 = valid_cnt; cycles = 0; seen = 0;
    send({$urandom, $urandom, $urandom, $urandom}, 1, 1);
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clock);
      cycles++;
      seen = err_timeout;
      tick();
    end
    chk("t3_err_cycle", cycles, TIMEOUT + 3);
    repeat (3) tick();
    chk("t3_core_rst_pulses", rst_cnt - r0, 1);
    chk("t3_no_pt_valid", valid_cnt - v0, 0);
    chk("t3_idle", busy, 0);

    // 4: no key yet, then key_load with s_ct_valid in the same cycle
    do_reset();
    cur_lat = 4; cur_hang = 0;
    s_ct_data = CT_FIPS; s_ct_valid = 1'b1;
    repeat (3) begin
      @(negedge clock);
      chk("t4_no_key_ready", s_ct_ready, 0);
      tick();
    end
    key_in = K_FIPS; key_load = 1'b1;
    @(negedge clock);
    chk("t4_ready_during_load", s_ct_ready, 0);
    tick();
    key_load = 1'b0;
    @(negedge clock);
    chk("t4_ready_after_load", s_ct_ready, 1);
    tick();
    s_ct_valid = 1'b0;
    @(negedge clock);
    chk("t4_taken", busy, 1);
    wait_idle(0);
    chk("t4_pt", last_out, PT_FIPS);

    // 5: SP800-38A CBC blocks 1-2 (raw ECB output when chaining is not built in)
    do_reset();
    load_key(K_SP, IV_SP);
    send(CT1, 6, 0);
    wait_idle(0);
    chk("t5_block1", last_out, CBC ? PT1 : (PT1 ^ IV_SP));
    send(CT2, 2, 0);
    wait_idle(0);
    chk("t5_block2", last_out, CBC ? PT2 : (PT2 ^ CT1));

    // random traffic, includes done exactly at the watchdog limit
    for (int i = 0; i < 600; i++) begin
      s_ct_valid = ($urandom % 3) != 0;
      s_ct_data  = {$urandom, $urandom, $urandom, $urandom};
      key_load   = ($urandom % 20) == 0;
      key_in     = {$urandom, $urandom, $urandom, $urandom};
      iv_in      = {$urandom, $urandom, $urandom, $urandom};
      m_pt_ready = $urandom_range(0, 1);
      cur_hang   = ($urandom % 12) == 0;
      cur_lat    = (($urandom % 4) == 0) ? TIMEOUT : $urandom_range(1, 8);
      tick();
    end
    s_ct_valid = 1'b0; key_load = 1'b0;
    wait_idle(1);

    // 6: reset while waiting on the core
    do_reset();
    load_key(K_FIPS, IV_SP);
    send({$urandom, $urandom, $urandom, $urandom}, 10, 0);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    @(negedge clock);
    chk("t6_busy", busy, 0);
    chk("t6_m_pt_valid", m_pt_valid, 0);
    chk("t6_m_pt_data", m_pt_data, 0);
    chk("t6_core_ct", core_ct, 0);
    chk("t6_core_key", core_key, 0);
    chk("t6_core_decrypt", core_decrypt, 0);
    chk("t6_core_rst", core_rst, 0);
    chk("t6_err", err_timeout, 0);
    reset = 1'b0;
    s_ct_valid = 1'b1;
    tick();
    @(negedge clock);
    chk("t6_key_reload_needed", s_ct_ready, 0);
    s_ct_valid = 1'b0;
    tick();

    // blk_count wrap
    load_key(K_FIPS, IV_SP);
    m_pt_ready = 1'b1;
    for (int b = 0; b < (1 << BLK_CNT_W); b++) begin
      send({$urandom, $urandom, $urandom, $urandom}, 1, 0);
      wait_idle(0);
      if (b == (1 << BLK_CNT_W) - 2) chk("t6_count_max", blk_count, (1 << BLK_CNT_W) - 1);
    end
    chk("t6_count_wrap", blk_count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench timeout");
  end

endmodule
